// File: rtl/line_sched.sv
// Segment scheduler: round-robin intake from two requesters into a small FIFO,
// one-at-a-time issue to the line rasterizer during vblank, with a completion watchdog.
module line_sched #(
   parameter int unsigned W       = 10,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 4095
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    vblank,
   input  logic                    req0_valid,
   input  logic [4*W-1:0]          req0_seg,
   output logic                    req0_ready,
   input  logic                    req1_valid,
   input  logic [4*W-1:0]          req1_seg,
   output logic                    req1_ready,
   output logic                    eng_start,
   output logic [4*W-1:0]          eng_seg,
   input  logic                    eng_busy,
   input  logic                    eng_done,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    timeout_err
);

   localparam int unsigned SW = 4 * W;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_rr;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             r_eng_start;
   logic [SW-1:0]    r_eng_seg;
   logic             r_timeout;
   logic [SW-1:0]    r_mem [DEPTH];

   logic             w_full;
   logic             w_empty;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_push0;
   logic             w_push1;
   logic             w_push;
   logic             w_issue;
   logic             w_timeout;
   logic [SW-1:0]    w_in_seg;
   logic [SW-1:0]    w_norm_seg;
   logic [W-1:0]     w_x1;
   logic [W-1:0]     w_y1;
   logic [W-1:0]     w_x2;
   logic [W-1:0]     w_y2;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);

   // Preferred requester wins when valid; otherwise the other one may go.
   assign w_grant0 = r_rr ? ~req1_valid : 1'b1;
   assign w_grant1 = r_rr ? 1'b1 : ~req0_valid;

   assign req0_ready = ~reset & ~w_full & req0_valid & w_grant0;
   assign req1_ready = ~reset & ~w_full & req1_valid & w_grant1;

   assign w_push0 = req0_valid & req0_ready;
   assign w_push1 = req1_valid & req1_ready;
   assign w_push  = w_push0 | w_push1;

   assign w_in_seg = w_push0 ? req0_seg : req1_seg;
   assign w_x1 = w_in_seg[SW-1   -: W];
   assign w_y1 = w_in_seg[3*W-1  -: W];
   assign w_x2 = w_in_seg[2*W-1  -: W];
   assign w_y2 = w_in_seg[W-1    -: W];

   // Engine expects left-to-right segments, so swap endpoints when x1 > x2.
   assign w_norm_seg = (w_x1 > w_x2) ? {w_x2, w_y2, w_x1, w_y1} : w_in_seg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_rr     <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            r_rr     <= w_push0;
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_issue})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_norm_seg;
      end
   end

   // Issue and watchdog control; done wins over a coincident terminal count.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_issue     = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty && vblank && !eng_busy) begin
               w_issue     = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (eng_done) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_eng_start <= 1'b0;
         r_eng_seg   <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_eng_start <= w_issue;
         r_timeout   <= w_timeout;
         if (w_issue) begin
            r_eng_seg <= r_mem[r_rd_ptr];
         end
      end
   end

   assign eng_start   = r_eng_start;
   assign eng_seg     = r_eng_seg;
   assign level       = r_level;
   assign timeout_err = r_timeout;

endmodule
